// File: rtl/arinc429_pkg.sv
// ARINC 429 receiver shared types, constants and bit-time divisor.
package arinc429_pkg;

    localparam logic [1:0] VEL_12K5 = 2'b00;
    localparam logic [1:0] VEL_50K  = 2'b01;
    localparam logic [1:0] VEL_100K = 2'b10;

    localparam int WORD_BITS  = 32;
    localparam int LABEL_BITS = 8;
    localparam int BODY_BITS  = 23;
    localparam int CNT_W      = 14;

    typedef enum logic [1:0] {
        LVL_NULL,
        LVL_HI,
        LVL_LO,
        LVL_INV
    } level_t;

    typedef enum logic [2:0] {
        S_WAIT_GAP,
        S_IDLE,
        S_SAMPLE,
        S_RZ,
        S_NEXT,
        S_DONE
    } state_t;

    function automatic logic [CNT_W-1:0] bit_t(input int clk_hz,
                                               input logic [1:0] vel);
        int d;
        if (vel[1])      d = clk_hz / 100000;
        else if (vel[0]) d = clk_hz / 50000;
        else             d = clk_hz / 12500;
        return CNT_W'(d);
    endfunction

endpackage

// File: rtl/arinc429_rx_if.sv
// Received-word bundle driven by the ARINC 429 receiver.
interface arinc429_rx_if;

    logic [7:0]  ADR;
    logic [22:0] DAT;
    logic        VALID;
    logic        PAR_ERR;
    logic        FRM_ERR;
    logic        BUSY;

    modport master (
        output ADR, DAT, VALID, PAR_ERR, FRM_ERR, BUSY
    );

    modport slave (
        input ADR, DAT, VALID, PAR_ERR, FRM_ERR, BUSY
    );

endinterface

// File: rtl/arinc429_rx_level.sv
// Two-flop synchronizer on RXA/RXB followed by bipolar level decode.
module arinc429_rx_level
    import arinc429_pkg::*;
(
    input  logic   CLK,
    input  logic   rst_n,
    input  logic   RXA,
    input  logic   RXB,
    output level_t level
);

    logic [1:0] a_q, a_d;
    logic [1:0] b_q, b_d;

    assign a_d = {a_q[0], RXA};
    assign b_d = {b_q[0], RXB};

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    always_comb begin
        level = LVL_INV;
        case ({a_q[1], b_q[1]})
            2'b00:   level = LVL_NULL;
            2'b10:   level = LVL_HI;
            2'b01:   level = LVL_LO;
            default: level = LVL_INV;
        endcase
    end

endmodule

// File: rtl/arinc429_rx.sv
// ARINC 429 bipolar RZ word receiver with framing and odd-parity check.
// Optional label filter: define ARINC429_RX_LABEL_FILTER_EN.
module arinc429_rx
    import arinc429_pkg::*;
#(
    parameter int CLK_HZ   = 50000000,
    parameter int GAP_BITS = 3
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [1:0]    VEL,
    input  logic          RXA,
    input  logic          RXB,
    input  logic [7:0]    FILT_ADR,
    arinc429_rx_if.master rx
);

    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n = rst_sync_q[1];

    level_t lvl;

    arinc429_rx_level u_level (
        .CLK   (CLK),
        .rst_n (rst_n),
        .RXA   (RXA),
        .RXB   (RXB),
        .level (lvl)
    );

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      bt_q, bt_d;
    logic [5:0]            bit_cnt_q, bit_cnt_d;
    logic [WORD_BITS-1:0]  sh_q, sh_d;
    logic [LABEL_BITS-1:0] adr_q, adr_d;
    logic [BODY_BITS-1:0]  dat_q, dat_d;
    logic                  par_q, par_d;
    logic                  valid_q, valid_d;
    logic                  frm_q, frm_d;
    logic                  busy_q, busy_d;

    logic [BODY_BITS-1:0]  body;
    logic [CNT_W-1:0]      gap_t;
    logic                  edge_seen;
    logic                  accept;
    logic                  abort;

    assign gap_t     = CNT_W'(GAP_BITS) * bit_t(CLK_HZ, VEL);
    assign edge_seen = (lvl == LVL_HI) || (lvl == LVL_LO);

    // Wire bit 9 sits at sh_q[23], wire bit 31 at sh_q[1].
    always_comb begin
        body = '0;
        for (int i = 0; i < BODY_BITS; i++) body[i] = sh_q[BODY_BITS - i];
    end

`ifdef ARINC429_RX_LABEL_FILTER_EN
    assign accept = (sh_q[WORD_BITS-1 -: LABEL_BITS] == FILT_ADR);
`else
    assign accept = 1'b1 | (^FILT_ADR);
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bt_d      = bt_q;
        bit_cnt_d = bit_cnt_q;
        sh_d      = sh_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        par_d     = par_q;
        busy_d    = busy_q;
        valid_d   = 1'b0;
        frm_d     = 1'b0;
        abort     = 1'b0;
        case (state_q)
            S_WAIT_GAP: begin
                if (lvl != LVL_NULL)     cnt_d   = '0;
                else if (cnt_q >= gap_t) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (edge_seen) begin
                    bt_d      = bit_t(CLK_HZ, VEL);
                    bit_cnt_d = '0;
                    busy_d    = 1'b1;
                    cnt_d     = 14'd1;
                    state_d   = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (cnt_q >= (bt_q >> 2)) begin
                    if (edge_seen) begin
                        sh_d      = {sh_q[WORD_BITS-2:0], lvl == LVL_HI};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        state_d   = S_RZ;
                    end else begin
                        abort = 1'b1;
                    end
                end
            end
            S_RZ: begin
                if (lvl == LVL_NULL)    state_d = S_NEXT;
                else if (cnt_q >= bt_q) abort   = 1'b1;
            end
            S_NEXT: begin
                if (bit_cnt_q == 6'(WORD_BITS)) begin
                    state_d = S_DONE;
                end else if (edge_seen) begin
                    cnt_d   = 14'd1;
                    state_d = S_SAMPLE;
                end else if (cnt_q >= (bt_q << 1)) begin
                    abort = 1'b1;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = S_WAIT_GAP;
                if (accept) begin
                    adr_d   = sh_q[WORD_BITS-1 -: LABEL_BITS];
                    dat_d   = body;
                    par_d   = ~(^sh_q);
                    valid_d = 1'b1;
                end
            end
            default: state_d = S_WAIT_GAP;
        endcase
        if (abort) begin
            frm_d   = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = '0;
            state_d = S_WAIT_GAP;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_WAIT_GAP;
            cnt_q     <= '0;
            bt_q      <= '0;
            bit_cnt_q <= '0;
            sh_q      <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            par_q     <= 1'b0;
            valid_q   <= 1'b0;
            frm_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bt_q      <= bt_d;
            bit_cnt_q <= bit_cnt_d;
            sh_q      <= sh_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            par_q     <= par_d;
            valid_q   <= valid_d;
            frm_q     <= frm_d;
            busy_q    <= busy_d;
        end
    end

    assign rx.ADR     = adr_q;
    assign rx.DAT     = dat_q;
    assign rx.PAR_ERR = par_q;
    assign rx.VALID   = valid_q;
    assign rx.FRM_ERR = frm_q;
    assign rx.BUSY    = busy_q;

endmodule

// File: tb/tb_arinc429_rx.sv
// Bench for arinc429_rx: drives encoded RZ words, checks against a word-level model.
module tb_arinc429_rx;
    import arinc429_pkg::*;

    localparam int CLK_HZ = 1000000;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b1;
    logic [1:0] VEL = 2'b00;
    logic       RXA = 1'b0;
    logic       RXB = 1'b0;
    logic [7:0] FILT_ADR = 8'h00;

    arinc429_rx_if rx_if();

    arinc429_rx #(.CLK_HZ(CLK_HZ), .GAP_BITS(3)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .VEL      (VEL),
        .RXA      (RXA),
        .RXB      (RXB),
        .FILT_ADR (FILT_ADR),
        .rx       (rx_if)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int v_cnt = 0;
    int f_cnt = 0;
    int both_cnt = 0;
    logic [7:0]  cap_adr = '0;
    logic [22:0] cap_dat = '0;
    logic        cap_par = 1'b0;

    always @(negedge CLK) begin
        if (rx_if.VALID) begin
            v_cnt++;
            cap_adr = rx_if.ADR;
            cap_dat = rx_if.DAT;
            cap_par = rx_if.PAR_ERR;
        end
        if (rx_if.FRM_ERR) f_cnt++;
        if (rx_if.VALID && rx_if.FRM_ERR) both_cnt++;
    end

    function automatic int bt_of(input logic [1:0] v);
        int rate;
        if (v[1])      rate = 100000;
        else if (v[0]) rate = 50000;
        else           rate = 12500;
        return CLK_HZ / rate;
    endfunction

    // Odd parity over label, body and parity bit.
    function automatic logic exp_pe(input logic [7:0] l, input logic [22:0] d,
                                    input logic p);
        return ($countones({l, d, p}) % 2) == 0;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic drive(input int lv);
        if (lv == 1)      begin RXA = 1'b1; RXB = 1'b0; end
        else if (lv == 0) begin RXA = 1'b0; RXB = 1'b1; end
        else              begin RXA = 1'b0; RXB = 1'b0; end
    endtask

    task automatic send_word(input logic [1:0] vel, input int gap,
                             input logic [7:0] lab, input logic [22:0] dat,
                             input logic par, input int glitch, input int nbits,
                             input bit scramble, input bit match);
        int   bt;
        logic wb[32];
        bt = bt_of(vel);
        for (int k = 0; k < 8; k++)  wb[k] = lab[7-k];
        for (int k = 0; k < 23; k++) wb[8+k] = dat[k];
        wb[31] = par;
        VEL = vel;
        FILT_ADR = match ? lab : ~lab;
        drive(2);
        repeat (gap * bt) @(negedge CLK);
        for (int i = 0; i < nbits; i++) begin
            if (scramble && i == 16) VEL = ~vel;
            if (i + 1 == glitch) begin
                drive(1);
                @(negedge CLK);
                drive(2);
                repeat (bt - 1) @(negedge CLK);
            end else begin
                drive(wb[i] ? 1 : 0);
                repeat (bt / 2) @(negedge CLK);
                drive(2);
                repeat (bt - bt / 2) @(negedge CLK);
            end
        end
    endtask

    task automatic test_reset();
        n_cmp++; if (rx_if.ADR !== 8'h00) begin n_bad++; $display("FAIL rst_adr got %h want 00", rx_if.ADR); end
        n_cmp++; if (rx_if.DAT !== 23'h0) begin n_bad++; $display("FAIL rst_dat got %h want 0", rx_if.DAT); end
        n_cmp++; if (rx_if.VALID !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", rx_if.VALID); end
        n_cmp++; if (rx_if.PAR_ERR !== 1'b0) begin n_bad++; $display("FAIL rst_par got %b want 0", rx_if.PAR_ERR); end
        n_cmp++; if (rx_if.FRM_ERR !== 1'b0) begin n_bad++; $display("FAIL rst_frm got %b want 0", rx_if.FRM_ERR); end
        n_cmp++; if (rx_if.BUSY !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", rx_if.BUSY); end
    endtask

    task automatic test_fast_word();
        int v0, f0;
        v0 = v_cnt; f0 = f_cnt;
        send_word(2'b10, 4, 8'h84, 23'h1FFAAB, 1'b1, 0, 32, 1'b0, 1'b1);
        idle(4);
        n_cmp++; if (v_cnt - v0 !== 1) begin n_bad++; $display("FAIL fast_valid got %0d want 1", v_cnt - v0); end
        n_cmp++; if (f_cnt - f0 !== 0) begin n_bad++; $display("FAIL fast_frm got %0d want 0", f_cnt - f0); end
        n_cmp++; if (cap_adr !== 8'h84) begin n_bad++; $display("FAIL fast_adr got %h want 84", cap_adr); end
        n_cmp++; if (cap_dat !== 23'h1FFAAB) begin n_bad++; $display("FAIL fast_dat got %h want 1ffaab", cap_dat); end
        n_cmp++; if (cap_par !== exp_pe(8'h84, 23'h1FFAAB, 1'b1)) begin n_bad++; $display("FAIL fast_par got %b want 0", cap_par); end
        n_cmp++; if (rx_if.ADR !== 8'h84) begin n_bad++; $display("FAIL fast_hold got %h want 84", rx_if.ADR); end
        n_cmp++; if (rx_if.BUSY !== 1'b0) begin n_bad++; $display("FAIL fast_busy got %b want 0", rx_if.BUSY); end
    endtask

    task automatic test_slow_parity();
        int v0;
        v0 = v_cnt;
        send_word(2'b00, 4, 8'h84, 23'h1FFAAB, 1'b0, 0, 32, 1'b0, 1'b1);
        idle(4);
        n_cmp++; if (v_cnt - v0 !== 1) begin n_bad++; $display("FAIL slow_valid got %0d want 1", v_cnt - v0); end
        n_cmp++; if (cap_par !== exp_pe(8'h84, 23'h1FFAAB, 1'b0)) begin n_bad++; $display("FAIL slow_par got %b want 1", cap_par); end
        n_cmp++; if (cap_dat !== 23'h1FFAAB) begin n_bad++; $display("FAIL slow_dat got %h want 1ffaab", cap_dat); end
    endtask

    task automatic test_abort();
        int v0, f0;
        logic [22:0] d;
        v0 = v_cnt; f0 = f_cnt;
        d = 23'($urandom);
        send_word(2'b01, 4, 8'h3C, d, 1'b1, 10, 32, 1'b0, 1'b1);
        idle(4);
        n_cmp++; if (f_cnt - f0 !== 1) begin n_bad++; $display("FAIL abort_frm got %0d want 1", f_cnt - f0); end
        n_cmp++; if (v_cnt - v0 !== 0) begin n_bad++; $display("FAIL abort_valid got %0d want 0", v_cnt - v0); end
        n_cmp++; if (rx_if.ADR !== 8'h84) begin n_bad++; $display("FAIL abort_adr got %h want 84", rx_if.ADR); end
        n_cmp++; if (rx_if.DAT !== 23'h1FFAAB) begin n_bad++; $display("FAIL abort_dat got %h want 1ffaab", rx_if.DAT); end
        n_cmp++; if (rx_if.PAR_ERR !== 1'b1) begin n_bad++; $display("FAIL abort_par got %b want 1", rx_if.PAR_ERR); end
        v0 = v_cnt;
        send_word(2'b01, 4, 8'h3C, d, 1'b0, 0, 32, 1'b0, 1'b1);
        idle(4);
        n_cmp++; if (v_cnt - v0 !== 1) begin n_bad++; $display("FAIL after_abort_valid got %0d want 1", v_cnt - v0); end
        n_cmp++; if (cap_dat !== d) begin n_bad++; $display("FAIL after_abort_dat got %h want %h", cap_dat, d); end
    endtask

    task automatic test_short_gap();
        int v0, f0;
        v0 = v_cnt;
        send_word(2'b10, 4, 8'h11, 23'h000123, 1'b1, 0, 32, 1'b0, 1'b1);
        idle(4);
        n_cmp++; if (v_cnt - v0 !== 1) begin n_bad++; $display("FAIL gapA_valid got %0d want 1", v_cnt - v0); end
        v0 = v_cnt; f0 = f_cnt;
        send_word(2'b10, 1, 8'h22, 23'h000456, 1'b1, 0, 32, 1'b0, 1'b1);
        idle(4);
        n_cmp++; if (v_cnt - v0 !== 0) begin n_bad++; $display("FAIL gapB_valid got %0d want 0", v_cnt - v0); end
        n_cmp++; if (f_cnt - f0 !== 0) begin n_bad++; $display("FAIL gapB_frm got %0d want 0", f_cnt - f0); end
        n_cmp++; if (rx_if.ADR !== 8'h11) begin n_bad++; $display("FAIL gapB_adr got %h want 11", rx_if.ADR); end
        v0 = v_cnt;
        send_word(2'b10, 4, 8'h5A, 23'h2A5A5A, 1'b0, 0, 32, 1'b0, 1'b1);
        idle(4);
        n_cmp++; if (v_cnt - v0 !== 1) begin n_bad++; $display("FAIL gapC_valid got %0d want 1", v_cnt - v0); end
        n_cmp++; if (cap_adr !== 8'h5A) begin n_bad++; $display("FAIL gapC_adr got %h want 5a", cap_adr); end
        n_cmp++; if (cap_dat !== 23'h2A5A5A) begin n_bad++; $display("FAIL gapC_dat got %h want 2a5a5a", cap_dat); end
    endtask

    task automatic test_reset_midword();
        int v0, f0;
        logic p;
        p = ^{8'hA5, 23'h3C3C3C};
        send_word(2'b01, 4, 8'hA5, 23'h3C3C3C, p, 0, 32, 1'b0, 1'b1);
        idle(4);
        n_cmp++; if (rx_if.PAR_ERR !== 1'b1) begin n_bad++; $display("FAIL pre_rst_par got %b want 1", rx_if.PAR_ERR); end
        f0 = f_cnt;
        send_word(2'b01, 4, 8'h66, 23'h777777, 1'b0, 0, 19, 1'b0, 1'b1);
        n_cmp++; if (rx_if.BUSY !== 1'b1) begin n_bad++; $display("FAIL mid_busy got %b want 1", rx_if.BUSY); end
        drive(1);
        idle(2);
        #2 RST_N = 1'b0;
        #1;
        n_cmp++; if (rx_if.ADR !== 8'h00) begin n_bad++; $display("FAIL mrst_adr got %h want 00", rx_if.ADR); end
        n_cmp++; if (rx_if.DAT !== 23'h0) begin n_bad++; $display("FAIL mrst_dat got %h want 0", rx_if.DAT); end
        n_cmp++; if (rx_if.PAR_ERR !== 1'b0) begin n_bad++; $display("FAIL mrst_par got %b want 0", rx_if.PAR_ERR); end
        n_cmp++; if (rx_if.BUSY !== 1'b0) begin n_bad++; $display("FAIL mrst_busy got %b want 0", rx_if.BUSY); end
        drive(2);
        idle(3);
        RST_N = 1'b1;
        idle(10);
        n_cmp++; if (f_cnt - f0 !== 0) begin n_bad++; $display("FAIL mrst_frm got %0d want 0", f_cnt - f0); end
        v0 = v_cnt;
        send_word(2'b01, 4, 8'h0F, 23'h0F0F0F, 1'b1, 0, 32, 1'b0, 1'b1);
        idle(4);
        n_cmp++; if (v_cnt - v0 !== 1) begin n_bad++; $display("FAIL post_rst_valid got %0d want 1", v_cnt - v0); end
        n_cmp++; if (cap_adr !== 8'h0F) begin n_bad++; $display("FAIL post_rst_adr got %h want 0f", cap_adr); end
        n_cmp++; if (cap_dat !== 23'h0F0F0F) begin n_bad++; $display("FAIL post_rst_dat got %h want 0f0f0f", cap_dat); end
    endtask

    task automatic test_random();
        int v0, f0;
        logic [1:0] vel;
        logic [7:0] lab;
        logic [22:0] dat;
        logic par;
        bit scr;
        for (int n = 0; n < 6; n++) begin
            vel = 2'($urandom_range(0, 3));
            lab = 8'($urandom);
            dat = 23'($urandom);
            par = 1'($urandom_range(0, 1));
            scr = 1'($urandom_range(0, 1));
            v0 = v_cnt; f0 = f_cnt;
            send_word(vel, 4, lab, dat, par, 0, 32, scr, 1'b1);
            idle(4);
            n_cmp++; if (v_cnt - v0 !== 1) begin n_bad++; $display("FAIL rnd%0d_valid got %0d want 1", n, v_cnt - v0); end
            n_cmp++; if (f_cnt - f0 !== 0) begin n_bad++; $display("FAIL rnd%0d_frm got %0d want 0", n, f_cnt - f0); end
            n_cmp++; if (cap_adr !== lab) begin n_bad++; $display("FAIL rnd%0d_adr got %h want %h", n, cap_adr, lab); end
            n_cmp++; if (cap_dat !== dat) begin n_bad++; $display("FAIL rnd%0d_dat got %h want %h", n, cap_dat, dat); end
            n_cmp++; if (cap_par !== exp_pe(lab, dat, par)) begin n_bad++; $display("FAIL rnd%0d_par got %b want %b", n, cap_par, exp_pe(lab, dat, par)); end
        end
    endtask

    task automatic test_filter();
        int v0, f0, want;
`ifdef ARINC429_RX_LABEL_FILTER_EN
        want = 0;
`else
        want = 1;
`endif
        v0 = v_cnt; f0 = f_cnt;
        FILT_ADR = 8'h84;
        send_word(2'b10, 4, 8'h85, 23'h012345, 1'b1, 0, 32, 1'b0, 1'b0);
        idle(4);
        n_cmp++; if (v_cnt - v0 !== want) begin n_bad++; $display("FAIL filt_drop_valid got %0d want %0d", v_cnt - v0, want); end
        n_cmp++; if (f_cnt - f0 !== 0) begin n_bad++; $display("FAIL filt_drop_frm got %0d want 0", f_cnt - f0); end
        v0 = v_cnt;
        send_word(2'b10, 4, 8'h84, 23'h054321, 1'b1, 0, 32, 1'b0, 1'b1);
        idle(4);
        n_cmp++; if (v_cnt - v0 !== 1) begin n_bad++; $display("FAIL filt_pass_valid got %0d want 1", v_cnt - v0); end
        n_cmp++; if (cap_dat !== 23'h054321) begin n_bad++; $display("FAIL filt_pass_dat got %h want 054321", cap_dat); end
    endtask

    task automatic test_exclusive();
        n_cmp++; if (both_cnt !== 0) begin n_bad++; $display("FAIL valid_frm_overlap got %0d want 0", both_cnt); end
    endtask

    initial begin
        #2 RST_N = 1'b0;
        idle(4);
        test_reset();
        RST_N = 1'b1;
        idle(2);
        test_fast_word();
        test_slow_parity();
        test_abort();
        test_short_gap();
        test_reset_midword();
        test_random();
        test_filter();
        test_exclusive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
